// File: rtl/branch_control.sv
// Branch/control unit: jump-condition select, edge-latched maskable interrupt dispatch, stack-depth tracking.
// Optional return-stack guard enabled by defining HS_STACK_GUARD_EN.
module branch_control #(
  parameter int NUM_TIMERS  = 1,
  parameter int NUM_VARS    = 1,
  parameter int NUM_IRQ     = 1,
  parameter int STACK_DEPTH = 8,
  parameter int VSEL_W      = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1,
  parameter int IRQ_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_TIMERS-1:0] timer_done,
  input  logic [NUM_TIMERS-1:0] timer_sel,
  input  logic [NUM_VARS-1:0]   var_in,
  input  logic [VSEL_W-1:0]     var_sel,
  input  logic                  var_or_timer,
  input  logic                  invert,
  input  logic                  branch,
  input  logic                  forced_jmp,
  input  logic                  sub,
  input  logic                  rtn,
  input  logic [NUM_IRQ-1:0]    irq,
  input  logic [NUM_IRQ-1:0]    irq_mask,
  output logic                  jadr,
  output logic                  sub_push,
  output logic                  sub_pop,
  output logic                  fired,
  output logic [IRQ_W-1:0]      irq_vec,
  output logic                  irq_active,
  output logic [DEPTH_W-1:0]    depth,
  output logic                  stack_err
);

  logic [NUM_IRQ-1:0] r_irq_r;
  logic [NUM_IRQ-1:0] r_pending;
  logic               r_fired;
  logic [IRQ_W-1:0]   r_irq_vec;
  logic               r_irq_active;
  logic [DEPTH_W-1:0] r_depth;
  logic [DEPTH_W-1:0] r_isr_base;

  logic               w_var;
  logic               w_c;
  logic               w_push_req;
  logic               w_push;
  logic               w_pop;
  logic               w_disp_ok;
  logic [NUM_IRQ-1:0] w_avail;
  logic [NUM_IRQ-1:0] w_low;
  logic [IRQ_W-1:0]   w_k;
  logic               w_req;
  logic               w_isr_done;

  // Out-of-range var_sel selects nothing and reads as 0.
  always_comb begin
    w_var = 1'b0;
    for (int i = 0; i < NUM_VARS; i++)
      if (int'(var_sel) == i) w_var = var_in[i];
  end

  assign w_c        = (var_or_timer ? |(timer_done & timer_sel) : w_var) ^ invert;
  assign jadr       = ((~w_c | sub) & branch) | forced_jmp;
  assign w_push_req = (sub & branch) | r_fired;

`ifdef HS_STACK_GUARD_EN
  logic r_stack_err;
  logic w_full;
  logic w_empty;

  assign w_full    = (r_depth == DEPTH_W'(STACK_DEPTH));
  assign w_empty   = (r_depth == '0);
  assign w_push    = w_push_req & ~w_full;
  assign w_pop     = rtn & ~w_empty;
  assign w_disp_ok = ~w_full;
  assign stack_err = r_stack_err;

  always_ff @(posedge clk) begin
    if (rst)
      r_stack_err <= 1'b0;
    else if ((w_push_req & w_full) | (rtn & w_empty))
      r_stack_err <= 1'b1;
  end
`else
  assign w_push    = w_push_req;
  assign w_pop     = rtn;
  assign w_disp_ok = 1'b1;
  assign stack_err = 1'b0;
`endif

  // Lowest unmasked pending line wins; w_low isolates that single bit.
  assign w_avail = r_pending & ~irq_mask;
  assign w_low   = w_avail & (~w_avail + 1'b1);

  always_comb begin
    w_k = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (w_avail[i]) w_k = IRQ_W'(i);
  end

  // r_fired in the gate keeps the dispatch pulse from repeating back to back.
  assign w_req      = ~r_irq_active & ~r_fired & (|w_avail) & w_disp_ok;
  assign w_isr_done = r_irq_active & w_pop & ~w_push & (r_depth == r_isr_base + 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_r      <= '0;
      r_pending    <= '0;
      r_fired      <= 1'b0;
      r_irq_vec    <= '0;
      r_irq_active <= 1'b0;
      r_depth      <= '0;
      r_isr_base   <= '0;
    end else begin
      r_irq_r   <= irq;
      r_pending <= (r_pending & ~({NUM_IRQ{w_req}} & w_low)) | (irq & ~r_irq_r);
      r_fired   <= w_req;
      if (w_req) r_irq_vec <= w_k;
      if (r_fired) r_isr_base <= r_depth;
      if (w_req)
        r_irq_active <= 1'b1;
      else if (w_isr_done)
        r_irq_active <= 1'b0;
      if (w_push & ~w_pop)
        r_depth <= r_depth + 1'b1;
      else if (w_pop & ~w_push)
        r_depth <= r_depth - 1'b1;
    end
  end

  assign sub_push   = w_push;
  assign sub_pop    = w_pop;
  assign fired      = r_fired;
  assign irq_vec    = r_irq_vec;
  assign irq_active = r_irq_active;
  assign depth      = r_depth;

endmodule

// File: tb/tb_branch_control.sv
// Directed bench for branch_control: condition select, interrupt dispatch order, ISR nesting, stack bounds.
module tb_branch_control;

`ifdef HS_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] timer_done, timer_sel;
  logic [2:0] var_in;
  logic [1:0] var_sel;
  logic       var_or_timer, invert, branch, forced_jmp, sub, rtn;
  logic [3:0] irq, irq_mask;
  logic       jadr, sub_push, sub_pop, fired, irq_active, stack_err;
  logic [1:0] irq_vec;
  logic [1:0] depth;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];
  bit any_fired;

  branch_control #(
    .NUM_TIMERS(4), .NUM_VARS(3), .NUM_IRQ(4), .STACK_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .timer_done(timer_done), .timer_sel(timer_sel),
    .var_in(var_in), .var_sel(var_sel), .var_or_timer(var_or_timer),
    .invert(invert), .branch(branch), .forced_jmp(forced_jmp),
    .sub(sub), .rtn(rtn), .irq(irq), .irq_mask(irq_mask),
    .jadr(jadr), .sub_push(sub_push), .sub_pop(sub_pop), .fired(fired),
    .irq_vec(irq_vec), .irq_active(irq_active), .depth(depth), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a dispatch pulse and checks its vector against the scoreboard.
  task automatic dispatch(input string tag);
    int n;
    logic [1:0] e;
    n = 0;
    while (!fired && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_fired"}, 32'(fired), 1);
    e = exp_q.pop_front();
    check({tag, "_vec"}, 32'(irq_vec), 32'(e));
  endtask

  initial begin
    rst = 1'b1; timer_done = '0; timer_sel = '0; var_in = '0; var_sel = '0;
    var_or_timer = 0; invert = 0; branch = 0; forced_jmp = 0; sub = 0; rtn = 0;
    irq = '0; irq_mask = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_fired", 32'(fired), 0);
    check("rst_vec", 32'(irq_vec), 0);
    check("rst_active", 32'(irq_active), 0);
    check("rst_depth", 32'(depth), 0);
    check("rst_err", 32'(stack_err), 0);
    check("rst_push", 32'(sub_push), 0);

    // Variable condition select
    var_sel = 2'd2; var_in = 3'b100; branch = 1; #1;
    check("t1_var_true", 32'(jadr), 0);
    invert = 1; #1;
    check("t1_invert", 32'(jadr), 1);
    invert = 0; forced_jmp = 1; #1;
    check("t1_forced", 32'(jadr), 1);
    forced_jmp = 0; var_sel = 2'd3; var_in = 3'b111; #1;
    check("t1_oob_sel", 32'(jadr), 1);
    branch = 0; #1;
    check("t1_nobranch", 32'(jadr), 0);

    // Timer condition select
    var_or_timer = 1; timer_sel = 4'b0100; timer_done = 4'b0110; branch = 1; #1;
    check("t2_timer_hit", 32'(jadr), 0);
    timer_done = 4'b0010; #1;
    check("t2_timer_miss", 32'(jadr), 1);
    var_or_timer = 0; timer_sel = '0; timer_done = '0; branch = 0; var_sel = '0; var_in = '0;
    tick();
    check("t2_depth_idle", 32'(depth), 0);

    // Simultaneous edges dispatch lowest first
    exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    irq = 4'b1010;
    dispatch("t3a");
    check("t3a_push", 32'(sub_push), 1);
    check("t3a_active", 32'(irq_active), 1);
    tick();
    check("t3a_pulse", 32'(fired), 0);
    check("t3a_depth", 32'(depth), 1);
    check("t3a_vec_hold", 32'(irq_vec), 1);
    rtn = 1; #1;
    check("t3a_pop", 32'(sub_pop), 1);
    tick(); rtn = 0;
    check("t3a_ret_depth", 32'(depth), 0);
    check("t3a_ret_active", 32'(irq_active), 0);
    dispatch("t3b");
    tick();
    check("t3b_depth", 32'(depth), 1);
    rtn = 1; tick(); rtn = 0;
    check("t3b_ret_active", 32'(irq_active), 0);

    // Masked line stays pending until unmasked
    irq_mask = 4'b0001; irq = 4'b1011; any_fired = 0;
    repeat (20) begin
      tick();
      if (fired) any_fired = 1;
    end
    check("t4_masked", 32'(any_fired), 0);
    exp_q.push_back(2'd0);
    irq_mask = '0;
    dispatch("t4");
    tick();
    check("t4_active", 32'(irq_active), 1);

    // Nested call inside ISR; new edge only latches
    irq = 4'b1111; sub = 1; branch = 1; #1;
    check("t5_push", 32'(sub_push), 1);
    check("t5_jadr_call", 32'(jadr), 1);
    tick(); sub = 0; branch = 0;
    check("t5_depth2", 32'(depth), 2);
    check("t5_no_nest", 32'(fired), 0);
    rtn = 1; tick(); rtn = 0;
    check("t5_depth1", 32'(depth), 1);
    check("t5_still_active", 32'(irq_active), 1);
    rtn = 1; tick(); rtn = 0;
    check("t5_depth0", 32'(depth), 0);
    check("t5_isr_done", 32'(irq_active), 0);
    exp_q.push_back(2'd2);
    dispatch("t5_late");
    sub = 1; branch = 1; tick(); sub = 0; branch = 0;
    check("t5_single_push", 32'(depth), 1);
    rtn = 1; tick(); rtn = 0;
    check("t5_late_done", 32'(irq_active), 0);

    // Reset in the middle of an ISR drops pending edges
    irq = '0; tick(); tick();
    exp_q.push_back(2'd0);
    irq = 4'b0001;
    dispatch("t7");
    tick(); irq = 4'b0011; tick();
    rst = 1; irq = '0; tick(); rst = 0;
    check("t7_active", 32'(irq_active), 0);
    check("t7_depth", 32'(depth), 0);
    check("t7_vec", 32'(irq_vec), 0);
    any_fired = 0;
    repeat (10) begin
      tick();
      if (fired) any_fired = 1;
    end
    check("t7_lost", 32'(any_fired), 0);

    // Stack bounds
    sub = 1; branch = 1; tick(); tick();
    check("t6_full_depth", 32'(depth), 2);
    check("t6_third_push", 32'(sub_push), GUARD ? 0 : 1);
    tick(); sub = 0; branch = 0;
    check("t6_over_depth", 32'(depth), GUARD ? 2 : 3);
    check("t6_over_err", 32'(stack_err), GUARD ? 1 : 0);
    rst = 1; tick(); rst = 0;
    check("t6_rst_depth", 32'(depth), 0);
    check("t6_rst_err", 32'(stack_err), 0);
    rtn = 1; #1;
    check("t6_under_pop", 32'(sub_pop), GUARD ? 0 : 1);
    tick(); rtn = 0;
    check("t6_under_err", 32'(stack_err), GUARD ? 1 : 0);
    check("t6_under_depth", 32'(depth), GUARD ? 0 : 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
